// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice: feeds one operand bit pair per
// cycle (LSB first), chains the slice carry and assembles a WIDTH-bit result with flags.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             a_gt_b,
  output logic             err,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_ainv,
  output logic             alu_binv,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic             alu_result,
  input  logic             alu_carryout
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             gt_q, gt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_out_q, carry_out_d;
  logic             a_gt_b_q, a_gt_b_d;
  logic             err_q, err_d;

  logic             dec_ainv, dec_binv;
  logic [1:0]       dec_op;
  logic             run;
  logic [WIDTH-1:0] acc_next;
  logic             gt_next;

  always_comb begin
    dec_ainv = 1'b0;
    dec_binv = 1'b0;
    dec_op   = 2'b00;
    case (opcode_q)
      3'b001: dec_op = 2'b01;
      3'b010: begin dec_ainv = 1'b1; dec_binv = 1'b1; end
      3'b011: begin dec_ainv = 1'b1; dec_binv = 1'b1; dec_op = 2'b01; end
      3'b100: dec_op = 2'b10;
      3'b101: begin dec_binv = 1'b1; dec_op = 2'b10; end
      default: ;
    endcase
  end

  // Slice drive is gated so the shared ALU sees all-zero inputs outside RUN.
  assign run           = (state_q == S_RUN);
  assign alu_a         = run & opa_q[idx_q];
  assign alu_b         = run & opb_q[idx_q];
  assign alu_ainv      = run & dec_ainv;
  assign alu_binv      = run & dec_binv;
  assign alu_carryin   = run & carry_q;
  assign alu_operation = run ? dec_op : 2'b00;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opcode_d    = opcode_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    gt_d        = gt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    a_gt_b_d    = a_gt_b_q;
    err_d       = err_q;

    acc_next         = acc_q;
    acc_next[idx_q]  = alu_result;
    gt_next          = gt_q;
    if (alu_a & ~alu_b)      gt_next = 1'b1;
    else if (~alu_a & alu_b) gt_next = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d    = opa;
          opb_d    = opb;
          opcode_d = opcode;
          idx_d    = '0;
          carry_d  = (opcode == OP_SUB);
          gt_d     = 1'b0;
          acc_d    = '0;
          err_d    = 1'b0;
          if (opcode[2:1] != 2'b11) begin
            state_d = S_RUN;
          end else begin
            state_d     = S_DONE;
            result_d    = '0;
            zero_d      = 1'b1;
            carry_out_d = 1'b0;
            a_gt_b_d    = 1'b0;
            err_d       = 1'b1;
          end
        end
      end
      S_RUN: begin
        acc_d   = acc_next;
        carry_d = alu_carryout;
        gt_d    = gt_next;
        idx_d   = idx_q + IW'(1);
        // The last bit lands in the same edge as the result, so publish the bypassed values.
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          result_d    = acc_next;
          zero_d      = (acc_next == '0);
          carry_out_d = opcode_q[2] & alu_carryout;
          a_gt_b_d    = gt_next;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      opcode_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      gt_q        <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      a_gt_b_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opcode_q    <= opcode_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      gt_q        <= gt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      a_gt_b_q    <= a_gt_b_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign a_gt_b    = a_gt_b_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench: a behavioural ALU slice closes the loop, an arithmetic model predicts
// every output each cycle, and directed operations pin the model with literal results.
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_NOR = 3'b010, OP_NAND = 3'b011,
                         OP_ADD = 3'b100, OP_SUB = 3'b101;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] opa, opb;
  logic         busy, done, zero, carry_out, a_gt_b, err;
  logic [W-1:0] result;
  logic         alu_a, alu_b, alu_ainv, alu_binv, alu_carryin;
  logic [1:0]   alu_operation;
  logic         alu_result, alu_carryout;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry_out(carry_out),
    .a_gt_b(a_gt_b), .err(err), .alu_a(alu_a), .alu_b(alu_b), .alu_ainv(alu_ainv),
    .alu_binv(alu_binv), .alu_carryin(alu_carryin), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  always #5 clk = ~clk;

  // External combinational 1-bit ALU slice.
  logic sa, sb;
  always_comb begin
    sa = alu_a ^ alu_ainv;
    sb = alu_b ^ alu_binv;
    case (alu_operation)
      2'b00:   alu_result = sa & sb;
      2'b01:   alu_result = sa | sb;
      default: alu_result = sa ^ sb ^ alu_carryin;
    endcase
    alu_carryout = (sa & sb) | (sa & alu_carryin) | (sb & alu_carryin);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_res(input logic [2:0] op, input logic [W-1:0] a, b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic m_co(input logic [2:0] op, input logic [W-1:0] a, b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (op == OP_ADD) return s[W];
    if (op == OP_SUB) return (a >= b);
    return 1'b0;
  endfunction

  // {ainv, binv, operation} the slice must see for each legal opcode.
  function automatic logic [3:0] dec_tab(input logic [2:0] op);
    case (op)
      OP_AND:  return 4'b0000;
      OP_OR:   return 4'b0001;
      OP_NOR:  return 4'b1100;
      OP_NAND: return 4'b1101;
      OP_ADD:  return 4'b0010;
      default: return 4'b0110;
    endcase
  endfunction

  // Model: cnt = busy cycles still to come including this one; done is the last of them.
  int           cnt = 0;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b, e_res;
  logic         e_zero, e_co, e_gt, e_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 0; m_op <= '0; m_a <= '0; m_b <= '0;
      e_res <= '0; e_zero <= 1'b0; e_co <= 1'b0; e_gt <= 1'b0; e_err <= 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
        m_op <= opcode; m_a <= opa; m_b <= opb; e_err <= 1'b0;
        if (opcode[2:1] == 2'b11) begin
          cnt <= 1; e_res <= '0; e_zero <= 1'b1; e_co <= 1'b0; e_gt <= 1'b0; e_err <= 1'b1;
        end else begin
          cnt <= W + 1;
        end
      end
    end else begin
      cnt <= cnt - 1;
      if (cnt == 2) begin
        e_res  <= m_res(m_op, m_a, m_b);
        e_zero <= (m_res(m_op, m_a, m_b) == '0);
        e_co   <= m_co(m_op, m_a, m_b);
        e_gt   <= (m_a > m_b);
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, cnt > 0);
    check("done", done, cnt == 1);
    check("result", result, e_res);
    check("zero", zero, e_zero);
    check("carry_out", carry_out, e_co);
    check("a_gt_b", a_gt_b, e_gt);
    check("err", err, e_err);
    if (cnt >= 2) begin
      check("alu_a", alu_a, m_a[W+1-cnt]);
      check("alu_b", alu_b, m_b[W+1-cnt]);
      check("alu_decode", {alu_ainv, alu_binv, alu_operation}, dec_tab(m_op));
    end else begin
      check("alu_idle", {alu_a, alu_b, alu_ainv, alu_binv, alu_carryin, alu_operation}, 0);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a, b,
                        input logic [W-1:0] xr, input logic xc, xz, xg, xe, input int xlat);
    int lat;
    @(negedge clk);
    start = 1'b1; opcode = op; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = W'($urandom); opb = W'($urandom); opcode = 3'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " done_seen"}, done, 1);
    check({nm, " latency"}, lat, xlat);
    check({nm, " result"}, result, xr);
    check({nm, " carry_out"}, carry_out, xc);
    check({nm, " zero"}, zero, xz);
    check({nm, " a_gt_b"}, a_gt_b, xg);
    check({nm, " err"}, err, xe);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    logic [W-1:0] seen;
    reset = 1'b1; start = 1'b0; opcode = '0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    check("reset zero", zero, 0);

    run_op("add_3c_0f", OP_ADD, 8'h3C, 8'h0F, 8'h4B, 0, 0, 1, 0, 9);
    run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 1, 0, 9);
    run_op("sub_05_05", OP_SUB, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 9);
    run_op("and",       OP_AND, 8'hF0, 8'hCC, 8'hC0, 0, 0, 1, 0, 9);
    run_op("or",        OP_OR,  8'hF0, 8'hCC, 8'hFC, 0, 0, 1, 0, 9);
    run_op("nor",       OP_NOR, 8'hF0, 8'hCC, 8'h03, 0, 0, 1, 0, 9);
    run_op("nand",      OP_NAND, 8'hF0, 8'hCC, 8'h3F, 0, 0, 1, 0, 9);
    run_op("sub_7f_80", OP_SUB, 8'h7F, 8'h80, 8'hFF, 0, 0, 0, 0, 9);
    run_op("illegal_6", 3'b110, 8'h55, 8'hAA, 8'h00, 0, 1, 0, 1, 1);
    run_op("add_clr",   OP_ADD, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0, 9);
    run_op("illegal_7", 3'b111, 8'h12, 8'h34, 8'h00, 0, 1, 0, 1, 1);

    // Start presented during the DONE cycle must not be accepted.
    start = 1'b1; opcode = OP_ADD; opa = 8'h01; opb = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored busy", busy, 0);
    check("done_start_ignored err", err, 1);

    // Start mid-RUN with different operands is ignored.
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; opa = 8'h3C; opb = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; opcode = OP_SUB; opa = 8'hAA; opb = 8'h11;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; seen = '0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin ndone++; seen = result; end
      @(negedge clk);
    end
    check("midrun done_count", ndone, 1);
    check("midrun result", seen, 8'h4B);

    // Reset while bit 3 of an ADD is in the slice.
    start = 1'b1; opcode = OP_ADD; opa = 8'h3C; opb = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort flags", {zero, carry_out, a_gt_b, err}, 0);
    check("abort alu", {alu_a, alu_b, alu_ainv, alu_binv, alu_carryin, alu_operation}, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_op("add_after_reset", OP_ADD, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 9);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
